// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback.
// Optional ILLEGAL_TRAP_EN: illegal instructions park the FSM in HALT.
module mc_control_fsm #(
  parameter int ALUCTL_W = 5,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                alu_bit0,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [2:0]          imm_src,
  output logic                reg_write,
  output logic                illegal
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_LINK,
    S_LUI,
    S_AUIPC,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(5'b00000);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(5'b00001);
  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(5'b00010);
  localparam logic [ALUCTL_W-1:0] ALU_SRA = ALUCTL_W'(5'b00011);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(5'b00100);
  localparam logic [ALUCTL_W-1:0] ALU_XOR = ALUCTL_W'(5'b00101);
  localparam logic [ALUCTL_W-1:0] ALU_SLL = ALUCTL_W'(5'b00110);
  localparam logic [ALUCTL_W-1:0] ALU_SRL = ALUCTL_W'(5'b00111);
  localparam logic [ALUCTL_W-1:0] ALU_EQ  = ALUCTL_W'(5'b01001);
  localparam logic [ALUCTL_W-1:0] ALU_NEQ = ALUCTL_W'(5'b01010);
  localparam logic [ALUCTL_W-1:0] ALU_LTU = ALUCTL_W'(5'b01011);
  localparam logic [ALUCTL_W-1:0] ALU_LTS = ALUCTL_W'(5'b01101);
  localparam logic [ALUCTL_W-1:0] ALU_GEU = ALUCTL_W'(5'b01111);
  localparam logic [ALUCTL_W-1:0] ALU_GES = ALUCTL_W'(5'b10000);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t S_ILL = S_HALT;
`else
  localparam state_t S_ILL = S_FETCH;
`endif

  state_t state_q, state_d;

  // funct7b5 selects SUB only for register ops; SRA/SRL for both.
  function automatic logic [ALUCTL_W-1:0] arith_op(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_reg
  );
    logic [ALUCTL_W-1:0] r;
    unique case (f3)
      3'b000:  r = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_LTS;
      3'b011:  r = ALU_LTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic logic [ALUCTL_W-1:0] branch_op(
    input logic [2:0] f3
  );
    logic [ALUCTL_W-1:0] r;
    unique case (f3)
      3'b000:  r = ALU_EQ;
      3'b001:  r = ALU_NEQ;
      3'b100:  r = ALU_LTS;
      3'b101:  r = ALU_GES;
      3'b110:  r = ALU_LTU;
      3'b111:  r = ALU_GEU;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  logic br_f3_bad;
  assign br_f3_bad = (funct3[2:1] == 2'b01);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_R:      state_d = S_EXECR;
          OP_I:      state_d = S_EXECI;
          OP_BRANCH: state_d = br_f3_bad ? S_ILL : S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          default:   state_d = S_ILL;
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_JAL,
      S_LUI,
      S_AUIPC:    state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR_LINK;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = arith_op(funct3, funct7b5, 1'b1);
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = arith_op(funct3, funct7b5, 1'b0);
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = branch_op(funct3);
        pc_write    = alu_bit0;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_JALR_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      default: ;
    endcase
    // Reset aborts in-flight work: no writes, fetch datapath setup.
    if (reset) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b10;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b10;
      alu_control = ALU_ADD;
      reg_write   = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_HALT) && !reset;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    case (opcode)
      OP_LOAD,
      OP_I,
      OP_JALR:   imm_src = 3'b000;
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_JAL:    imm_src = 3'b011;
      OP_LUI,
      OP_AUIPC:  imm_src = 3'b100;
      default:   imm_src = 3'b000;
    endcase
  end

endmodule
